apb_tx_ctrl: RTL and testbench

- UART transmit controller. Sits directly upstream of the TX datapath (apb_tx_dp).
- Accepts a parallel word through a start/ready handshake and latches it.
- Generates baud-rate bit timing and sequences START, DATA and STOP bits.
- Drives the datapath's control inputs: tx_en, start_bit, end_bit, data_bit, bit_cnto, din.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/apb_baud_gen.sv | 43 ++++
 rtl/apb_tx_ctrl.sv | 147 ++++++++++++++
 tb/tb_apb_tx_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud divisor and frame width.
package uart_pkg;

    localparam int unsigned UART_CLKS_PER_BIT_DEF = 434;
    localparam int unsigned UART_MAX_W            = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Mask with the low nbits bits set, saturating at the frame width.
    function automatic logic [UART_MAX_W-1:0] uart_mask(input int unsigned nbits);
        logic [UART_MAX_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < UART_MAX_W; i++) begin
            if (i < nbits) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/apb_baud_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while enabled, bit_end is high in the last count.
module apb_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bit_end_q, bit_end_d;

    // bit_end is registered from the next count so it lines up with cnt_q == CNT_LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
        bit_end_d = (cnt_d == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q     <= '0;
            bit_end_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bit_end_q <= bit_end_d;
        end
    end

    assign bit_end = bit_end_q;

endmodule

// File: rtl/apb_tx_ctrl.sv
// UART transmit controller: latches a word and sequences START, DATA and STOP bit timing.
module apb_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  tx_start,
    input  logic [UART_MAX_W-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  tx_done,
    output logic                  tx_ovr,
    output logic                  tx_en,
    output logic                  start_bit,
    output logic                  end_bit,
    output logic [UART_MAX_W-1:0] data_bit,
    output logic [UART_MAX_W-1:0] bit_cnto,
    output logic [UART_MAX_W-1:0] din
);

    localparam int unsigned          FRAME_BITS = 1 + DATA_BITS + STOP_BITS;
    localparam logic [UART_MAX_W-1:0] DATA_MASK = uart_mask(DATA_BITS);
    localparam logic [UART_MAX_W-1:0] DATA_LAST = UART_MAX_W'(DATA_BITS - 1);
    localparam logic [UART_MAX_W-1:0] CNT_LAST  = UART_MAX_W'(FRAME_BITS - 1);

    uart_state_e           state_q, state_d;
    logic [UART_MAX_W-1:0] din_q, din_d;
    logic [UART_MAX_W-1:0] data_bit_q, data_bit_d;
    logic [UART_MAX_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  tx_done_q, tx_done_d;
    logic                  tx_ovr_q, tx_ovr_d;
    logic                  tx_en_q, tx_en_d;
    logic                  start_bit_q, start_bit_d;
    logic                  end_bit_q, end_bit_d;
    logic                  accept_c;
    logic                  bit_end;

    apb_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rstn   (rstn),
        .clear  (accept_c),
        .enable (tx_en_q),
        .bit_end(bit_end)
    );

    // Next state plus registered flags derived from the next state.
    always_comb begin
        state_d    = state_q;
        din_d      = din_q;
        data_bit_d = data_bit_q;
        bit_cnt_d  = bit_cnt_q;
        tx_done_d  = 1'b0;
        tx_ovr_d   = 1'b0;
        accept_c   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    accept_c = 1'b1;
                    din_d    = tx_data & DATA_MASK;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + UART_MAX_W'(1);
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + UART_MAX_W'(1);
                    if (data_bit_q == DATA_LAST) begin
                        data_bit_d = '0;
                        state_d    = ST_STOP;
                    end else begin
                        data_bit_d = data_bit_q + UART_MAX_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == CNT_LAST) begin
                        bit_cnt_d = '0;
                        tx_done_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + UART_MAX_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_IDLE && tx_start) begin
            tx_ovr_d = 1'b1;
        end

        tx_en_d     = (state_d != ST_IDLE);
        start_bit_d = (state_d == ST_START);
        end_bit_d   = (state_d == ST_STOP);
        tx_ready_d  = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            din_q       <= '0;
            data_bit_q  <= '0;
            bit_cnt_q   <= '0;
            tx_ready_q  <= 1'b1;
            tx_done_q   <= 1'b0;
            tx_ovr_q    <= 1'b0;
            tx_en_q     <= 1'b0;
            start_bit_q <= 1'b0;
            end_bit_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            din_q       <= din_d;
            data_bit_q  <= data_bit_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_ready_q  <= tx_ready_d;
            tx_done_q   <= tx_done_d;
            tx_ovr_q    <= tx_ovr_d;
            tx_en_q     <= tx_en_d;
            start_bit_q <= start_bit_d;
            end_bit_q   <= end_bit_d;
        end
    end

    assign tx_ready  = tx_ready_q;
    assign tx_done   = tx_done_q;
    assign tx_ovr    = tx_ovr_q;
    assign tx_en     = tx_en_q;
    assign start_bit = start_bit_q;
    assign end_bit   = end_bit_q;
    assign data_bit  = data_bit_q;
    assign bit_cnto  = bit_cnt_q;
    assign din       = din_q;

endmodule

// File: tb/tb_apb_tx_ctrl.sv
// Directed bench for apb_tx_ctrl: one 8N1 instance and one 5N2 instance, CLKS_PER_BIT=4.
module tb_apb_tx_ctrl;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rstn;

    logic       tx_start_a, tx_start_b;
    logic [9:0] tx_data_a, tx_data_b;
    logic       rdy_a, done_a, ovr_a, en_a, st_a, eb_a;
    logic       rdy_b, done_b, ovr_b, en_b, st_b, eb_b;
    logic [9:0] dbit_a, bc_a, din_a, dbit_b, bc_b, din_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Accumulators filled by watch()
    int en_cnt, st_cnt, end_cnt, done_cnt, ovr_cnt, bc_max;
    int model_err, din_err, excl_err, rdy_err, done_err;
    int frames, gap_cnt, gap_err, nline;
    logic [9:0] line_v;

    always #5 clk = ~clk;

    apb_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
        .clk(clk), .rstn(rstn), .tx_start(tx_start_a), .tx_data(tx_data_a),
        .tx_ready(rdy_a), .tx_done(done_a), .tx_ovr(ovr_a), .tx_en(en_a),
        .start_bit(st_a), .end_bit(eb_a), .data_bit(dbit_a), .bit_cnto(bc_a), .din(din_a)
    );

    apb_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .STOP_BITS(2)) dut_b (
        .clk(clk), .rstn(rstn), .tx_start(tx_start_b), .tx_data(tx_data_b),
        .tx_ready(rdy_b), .tx_done(done_b), .tx_ovr(ovr_b), .tx_en(en_b),
        .start_bit(st_b), .end_bit(eb_b), .data_bit(dbit_b), .bit_cnto(bc_b), .din(din_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) tx_start_b = v;
        else          tx_start_a = v;
    endtask

    // Present tx_start for exactly one rising edge; returns just after that edge.
    task automatic kick(input int sel, input logic [9:0] data);
        @(negedge clk);
        set_start(sel, 1'b1);
        if (sel != 0) tx_data_b = data;
        else          tx_data_a = data;
        @(posedge clk);
        #1;
        set_start(sel, 1'b0);
    endtask

    // Observe ncyc cycles on the falling edge, comparing against a frame-position model.
    task automatic watch(input int sel, input int ncyc, input logic [9:0] exp_din,
                         input int db, input int sb, input bit hold,
                         input int ov1, input int ov2);
        int   k;
        int   low_run;
        bit   prev_en;
        logic en, st, eb, done, ovr, rdy, ln;
        logic [9:0] dbit, bc, d;
        int   exp_db;
        logic exp_st, exp_eb;
        k = 0; low_run = 0; prev_en = 1'b0;
        en_cnt = 0; st_cnt = 0; end_cnt = 0; done_cnt = 0; ovr_cnt = 0; bc_max = 0;
        model_err = 0; din_err = 0; excl_err = 0; rdy_err = 0; done_err = 0;
        frames = 0; gap_cnt = 0; gap_err = 0; nline = 0; line_v = '0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            en   = (sel != 0) ? en_b   : en_a;
            st   = (sel != 0) ? st_b   : st_a;
            eb   = (sel != 0) ? eb_b   : eb_a;
            done = (sel != 0) ? done_b : done_a;
            ovr  = (sel != 0) ? ovr_b  : ovr_a;
            rdy  = (sel != 0) ? rdy_b  : rdy_a;
            dbit = (sel != 0) ? dbit_b : dbit_a;
            bc   = (sel != 0) ? bc_b   : bc_a;
            d    = (sel != 0) ? din_b  : din_a;
            if (en) begin
                if (!prev_en) begin
                    if (frames > 0) begin
                        gap_cnt++;
                        if (low_run != 1) gap_err++;
                    end
                    frames++;
                    nline = 0;
                    line_v = '0;
                end
                en_cnt++;
                exp_st = (k < CPB);
                exp_eb = (k >= (1 + db) * CPB);
                exp_db = (k >= CPB && k < (1 + db) * CPB) ? (k - CPB) / CPB : 0;
                if (st !== exp_st || eb !== exp_eb || int'(dbit) != exp_db ||
                    int'(bc) != k / CPB || rdy !== 1'b0)
                    model_err++;
                if (d !== exp_din) din_err++;
                if (k % CPB == CPB / 2 && nline < 10) begin
                    ln = st ? 1'b0 : (eb ? 1'b1 : d[dbit]);
                    line_v[nline] = ln;
                    nline++;
                end
                if (int'(bc) > bc_max) bc_max = int'(bc);
                k++;
                low_run = 0;
            end else begin
                if (st || eb || dbit != 10'd0 || bc != 10'd0) excl_err++;
                if (!rdy) rdy_err++;
                if (prev_en && !done) done_err++;
                k = 0;
                low_run++;
            end
            if (st && eb) excl_err++;
            if (done) done_cnt++;
            if (ovr) ovr_cnt++;
            prev_en = en;
            set_start(sel, hold || (en && ((k - 1) == ov1 || (k - 1) == ov2)));
        end
    endtask

    initial begin
        int waited;
        rstn = 1'b0;
        tx_start_a = 1'b0; tx_start_b = 1'b0;
        tx_data_a = '0; tx_data_b = '0;
        repeat (3) @(negedge clk);
        check("rst_ready_a", 32'(rdy_a), 32'd1);
        check("rst_en_a",    32'(en_a),  32'd0);
        check("rst_din_a",   32'(din_a), 32'd0);
        check("rst_ready_b", 32'(rdy_b), 32'd1);
        rstn = 1'b1;

        // Idle after reset
        watch(0, 50, 10'h000, 8, 1, 1'b0, -1, -1);
        check("idle_en",    32'(en_cnt),   32'd0);
        check("idle_flags", 32'(excl_err), 32'd0);
        check("idle_ready", 32'(rdy_err),  32'd0);
        check("idle_done",  32'(done_cnt + ovr_cnt), 32'd0);
        check("idle_din",   32'(din_a),    32'd0);

        // Single 8N1 frame of 0x055
        kick(0, 10'h055);
        watch(0, 45, 10'h055, 8, 1, 1'b0, -1, -1);
        check("f1_en_len",   32'(en_cnt),    32'd40);
        check("f1_start",    32'(st_cnt + 0) + 32'(model_err), 32'd0);
        check("f1_din",      32'(din_err),   32'd0);
        check("f1_done",     32'(done_cnt),  32'd1);
        check("f1_done_pos", 32'(done_err),  32'd0);
        check("f1_bc_max",   32'(bc_max),    32'd9);
        check("f1_line",     32'(line_v),    32'h2AA);
        check("f1_ovr",      32'(ovr_cnt),   32'd0);
        check("f1_idle",     32'(excl_err + rdy_err), 32'd0);

        // 5N2 instance with upper bits masked
        kick(1, 10'h3FF);
        #1 check("f2_din_mask", 32'(din_b), 32'h01F);
        watch(1, 40, 10'h01F, 5, 2, 1'b0, -1, -1);
        check("f2_en_len", 32'(en_cnt),   32'd32);
        check("f2_model",  32'(model_err), 32'd0);
        check("f2_din",    32'(din_err),  32'd0);
        check("f2_done",   32'(done_cnt), 32'd1);
        check("f2_line",   32'(line_v),   32'h0FE);

        // Requests while busy
        kick(0, 10'h055);
        tx_data_a = 10'h0AA;
        watch(0, 45, 10'h055, 8, 1, 1'b0, 10, 20);
        check("ovr_cnt",   32'(ovr_cnt),   32'd2);
        check("ovr_din",   32'(din_err),   32'd0);
        check("ovr_en",    32'(en_cnt),    32'd40);
        check("ovr_model", 32'(model_err), 32'd0);
        check("ovr_done",  32'(done_cnt),  32'd1);

        // tx_start held high: back-to-back frames
        @(negedge clk);
        tx_data_a  = 10'h0F0;
        tx_start_a = 1'b1;
        watch(0, 130, 10'h0F0, 8, 1, 1'b1, -1, -1);
        tx_start_a = 1'b0;
        check("b2b_frames", 32'(frames),   32'd4);
        check("b2b_gaps",   32'(gap_cnt),  32'd3);
        check("b2b_gap1",   32'(gap_err),  32'd0);
        check("b2b_done",   32'(done_cnt), 32'd3);
        check("b2b_model",  32'(model_err + din_err), 32'd0);
        waited = 0;
        while (!(rdy_a && !en_a) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("b2b_drain", 32'(rdy_a && !en_a), 32'd1);

        // Asynchronous reset during DATA bit 3
        kick(0, 10'h055);
        repeat (17) @(negedge clk);
        check("mr_in_data3", 32'(dbit_a), 32'd3);
        #2 rstn = 1'b0;
        #1;
        check("mr_en",    32'(en_a),   32'd0);
        check("mr_ready", 32'(rdy_a),  32'd1);
        check("mr_din",   32'(din_a),  32'd0);
        check("mr_cnts",  32'({dbit_a, bc_a}), 32'd0);
        watch(0, 10, 10'h000, 8, 1, 1'b0, -1, -1);
        check("mr_no_done", 32'(done_cnt + en_cnt), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        kick(0, 10'h0C3);
        watch(0, 45, 10'h0C3, 8, 1, 1'b0, -1, -1);
        check("mr_en_len", 32'(en_cnt),   32'd40);
        check("mr_model",  32'(model_err + din_err), 32'd0);
        check("mr_done",   32'(done_cnt), 32'd1);
        check("mr_line",   32'(line_v),   32'h386);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
